switch_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the traffic-light controller in the fpga top level, running on clk100.
- Synchronizes and debounces the raw board switches (sys_sw_a/b/c).
- Emits clean levels plus single-cycle rise/fall strobes per switch.
- Generates the periodic timing tick the controller uses to time light phases.

---
 rtl/switch_conditioner.sv | 93 +++++++++
 tb/tb_switch_conditioner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// Board switch conditioning: 2-flop sync + per-channel debounce with rise/fall strobes, plus a 1-in-TICK_DIV tick.
// Level/strobe latency is DEB_CYCLES+1 edges from the raw sample; no backpressure, outputs are flop-driven every cycle.
module switch_conditioner #(
  parameter int NUM_SW     = 3,
  parameter int DEB_CYCLES = 1000000,
  parameter int TICK_DIV   = 100000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_raw,
  input  logic              tick_clr,
  output logic [NUM_SW-1:0] sw_level,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  output logic              tick
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  logic [NUM_SW-1:0]         s1_q, s1_d;
  logic [NUM_SW-1:0]         s2_q, s2_d;
  logic [NUM_SW-1:0][CW-1:0] deb_cnt_q, deb_cnt_d;
  logic [NUM_SW-1:0]         level_q, level_d;
  logic [NUM_SW-1:0]         rise_q, rise_d;
  logic [NUM_SW-1:0]         fall_q, fall_d;
  logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
  logic                      tick_q, tick_d;

  always_comb begin
    s1_d      = sw_raw;
    s2_d      = s1_q;
    level_d   = level_q;
    deb_cnt_d = deb_cnt_q;
    rise_d    = '0;
    fall_d    = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      // Any sample agreeing with the accepted level restarts the stability window.
      if (s2_q[i] == level_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_MAX) begin
        level_d[i]   = s2_q[i];
        deb_cnt_d[i] = '0;
        rise_d[i]    = s2_q[i];
        fall_d[i]    = ~s2_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q + TW'(1);
    tick_d     = 1'b0;
    // A clear wins over a coincident wrap, suppressing that tick.
    if (tick_clr) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == TICK_MAX) begin
      tick_cnt_d = '0;
      tick_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_cnt_q  <= '0;
      level_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_cnt_q  <= deb_cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign sw_level = level_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner: a history-based reference model predicts every cycle's outputs.
module tb_switch_conditioner;

  localparam int NSW  = 3;
  localparam int DEB  = 4;
  localparam int TDIV = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NSW-1:0] sw_raw = '0;
  logic           tick_clr = 1'b0;
  logic [NSW-1:0] sw_level, sw_rise, sw_fall;
  logic           tick;

  switch_conditioner #(.NUM_SW(NSW), .DEB_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .tick_clr(tick_clr),
    .sw_level(sw_level), .sw_rise(sw_rise), .sw_fall(sw_fall), .tick(tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected {level, rise, fall, tick} for the cycle following each edge.
  logic [3*NSW:0] exp_q[$];

  // Reference model state: raw sample history since reset and event bookkeeping.
  int             edge_k;
  logic [NSW-1:0] hist[$];
  logic [NSW-1:0] m_lvl;
  int             last_chg[NSW];
  int             last_clr;

  function automatic logic [NSW-1:0] synced_at(input int e);
    // The value the debouncer judges at edge e is the raw sample taken two edges earlier.
    if (e >= 3) return hist[e-2];
    return '0;
  endfunction

  function automatic void model_reset();
    edge_k = 0;
    hist = {};
    hist.push_back('0);
    m_lvl = '0;
    for (int c = 0; c < NSW; c++) last_chg[c] = 0;
    last_clr = 0;
  endfunction

  function automatic void model_edge(input logic [NSW-1:0] raw, input logic clr);
    logic [NSW-1:0] r, f;
    logic           t, ok;
    edge_k++;
    hist.push_back(raw);
    r = '0;
    f = '0;
    for (int c = 0; c < NSW; c++) begin
      if (edge_k - last_chg[c] >= DEB) begin
        ok = 1'b1;
        for (int e = edge_k - DEB + 1; e <= edge_k; e++) begin
          logic [NSW-1:0] s;
          s = synced_at(e);
          if (s[c] == m_lvl[c]) ok = 1'b0;
        end
        if (ok) begin
          m_lvl[c]    = ~m_lvl[c];
          r[c]        = m_lvl[c];
          f[c]        = ~m_lvl[c];
          last_chg[c] = edge_k;
        end
      end
    end
    if (clr) begin
      last_clr = edge_k;
      t = 1'b0;
    end else begin
      t = ((edge_k - last_clr) % TDIV) == 0;
    end
    exp_q.push_back({m_lvl, r, f, t});
  endfunction

  task automatic step(input logic [NSW-1:0] raw, input logic clr);
    sw_raw   = raw;
    tick_clr = clr;
    @(posedge clk);
    model_edge(raw, clr);
    #1;
  endtask

  // Entered 1 time unit after an edge: reset hits mid-cycle, so the current cycle must already read zero.
  task automatic do_reset(input logic [NSW-1:0] raw, input int hold);
    reset    = 1'b1;
    sw_raw   = raw;
    tick_clr = 1'b0;
    model_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      exp_q.push_back('0);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic hold_raw(input logic [NSW-1:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [3*NSW:0] e, a;
      e = exp_q.pop_front();
      a = {sw_level, sw_rise, sw_fall, tick};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t level/rise/fall/tick got=%b_%b_%b_%b want=%b_%b_%b_%b", $time,
                 a[9:7], a[6:4], a[3:1], a[0], e[9:7], e[6:4], e[3:1], e[0]);
      end
    end
  end

  initial begin
    logic [NSW-1:0] cur;
    int             hold_left[NSW];
    #1;
    do_reset('0, 2);

    // Idle, then a mid-cycle reset, then two tick periods with no strobes.
    hold_raw(3'b000, 3);
    do_reset(3'b000, 2);
    hold_raw(3'b000, 25);

    // Single clean rise on channel 0.
    hold_raw(3'b001, 8);

    // Bounce on channel 1, then a short low glitch that must be rejected.
    hold_raw(3'b011, 3);
    hold_raw(3'b001, 1);
    hold_raw(3'b011, 8);
    hold_raw(3'b001, 3);
    hold_raw(3'b011, 8);

    // Release channels 0/1, then simultaneous rise on channels 0 and 2.
    hold_raw(3'b000, 8);
    hold_raw(3'b101, 8);

    // Switches already high through reset release.
    do_reset(3'b111, 2);
    hold_raw(3'b111, 10);

    // Clear on the would-be wrap edge.
    while (((edge_k + 1 - last_clr) % TDIV) != 0) step(3'b111, 1'b0);
    step(3'b111, 1'b1);
    hold_raw(3'b111, 25);

    // Reset interrupting a debounce count two cycles in.
    do_reset(3'b000, 2);
    hold_raw(3'b000, 6);
    hold_raw(3'b010, 4);
    do_reset(3'b000, 2);
    hold_raw(3'b000, 12);

    // Randomized hold times straddling the debounce window, with sporadic clears and resets.
    cur = '0;
    for (int c = 0; c < NSW; c++) hold_left[c] = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < NSW; c++) begin
        if (hold_left[c] == 0) begin
          cur[c]       = ~cur[c];
          hold_left[c] = $urandom_range(1, 8);
        end
        hold_left[c]--;
      end
      if ($urandom_range(0, 399) == 0) do_reset(cur, $urandom_range(1, 3));
      else step(cur, $urandom_range(0, 29) == 0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
